// File: rtl/bht_controller.sv
`timescale 1ns/1ps
// bht_controller
// Branch history table controller: owns ENTRIES 2-bit saturating counters,
// serves one lookup and one resolved-branch update per cycle, sweeps the
// table to INIT_VAL after reset or flush, and keeps saturating statistics.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               re-initialise the table (ignored while rst is high)
//   ready               table valid (READY state)
//   lu_valid, lu_pc     IF-stage lookup request
//   pred_valid/taken    registered prediction (1-cycle latency)
//   upd_valid, upd_pc   EX-stage resolved branch
//   upd_taken           actual outcome
//   upd_mispredict      EX detected a misprediction
//   stat_branches       accepted updates (saturating)
//   stat_mispred        accepted mispredicted updates (saturating)
module bht_controller #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned PC_W     = 32,
    parameter logic [1:0]  INIT_VAL = 2'b01,
    parameter int unsigned STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    output logic              ready,
    input  logic              lu_valid,
    input  logic [PC_W-1:0]   lu_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    typedef enum logic {S_INIT, S_READY} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [1:0]        cnt_q [ENTRIES];
    logic              pred_valid_q, pred_valid_d;
    logic              pred_taken_q, pred_taken_d;
    logic [STAT_W-1:0] stat_br_q, stat_br_d;
    logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

    logic [IDX_W-1:0]  lu_idx, upd_idx;
    logic [1:0]        upd_old, upd_new;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [1:0]        wr_val;

    // PC bits outside the index field do not select an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lu_pc[PC_W-1:IDX_W+2], lu_pc[1:0],
                              upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    assign lu_idx  = lu_pc[IDX_W+1:2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_old = cnt_q[upd_idx];

    // Saturating counter step.
    always_comb begin
        upd_new = upd_old;
        if (upd_taken) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        stat_br_d    = stat_br_q;
        stat_mis_d   = stat_mis_q;
        wr_en        = 1'b0;
        wr_idx       = ptr_q;
        wr_val       = INIT_VAL;
        case (state_q)
            S_INIT: begin
                if (flush) begin
                    ptr_d = '0;
                end else begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + IDX_W'(1);
                    if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = S_READY;
                end
            end
            S_READY: begin
                if (flush) begin
                    state_d = S_INIT;
                    ptr_d   = '0;
                end else begin
                    if (upd_valid) begin
                        wr_en  = 1'b1;
                        wr_idx = upd_idx;
                        wr_val = upd_new;
                        if (stat_br_q != '1) stat_br_d = stat_br_q + STAT_W'(1);
                        if (upd_mispredict && (stat_mis_q != '1))
                            stat_mis_d = stat_mis_q + STAT_W'(1);
                    end
                    if (lu_valid) begin
                        pred_valid_d = 1'b1;
                        // Same-index update this cycle: forward the new value.
                        if (upd_valid && (upd_idx == lu_idx))
                            pred_taken_d = upd_new[1];
                        else
                            pred_taken_d = cnt_q[lu_idx][1];
                    end
                end
            end
            default: begin
                state_d = S_INIT;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_INIT;
            ptr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            stat_br_q    <= '0;
            stat_mis_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            stat_br_q    <= stat_br_d;
            stat_mis_q   <= stat_mis_d;
        end
    end

    // Counter array has no reset; the INIT sweep defines its contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) cnt_q[wr_idx] <= wr_val;
    end

    assign ready         = (state_q == S_READY);
    assign pred_valid    = pred_valid_q;
    assign pred_taken    = pred_taken_q;
    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mis_q;

endmodule

// File: tb/tb_bht_controller.sv
`timescale 1ns/1ps
module tb_bht_controller;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (default parameters)
    logic        rst, flush, lu_valid, upd_valid, upd_taken, upd_mis;
    logic [31:0] lu_pc, upd_pc;
    logic        ready, pred_valid, pred_taken;
    logic [15:0] stat_br, stat_mis;

    bht_controller dut (
        .clk(clk), .rst(rst), .flush(flush), .ready(ready),
        .lu_valid(lu_valid), .lu_pc(lu_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(upd_mis),
        .stat_branches(stat_br), .stat_mispred(stat_mis)
    );

    // Second instance with narrow statistics for saturation
    logic        s_rst, s_flush, s_lu_valid, s_upd_valid, s_upd_taken, s_upd_mis;
    logic [31:0] s_lu_pc, s_upd_pc;
    logic        s_ready, s_pred_valid, s_pred_taken;
    logic [3:0]  s_stat_br, s_stat_mis;

    bht_controller #(.STAT_W(4)) dut_s (
        .clk(clk), .rst(s_rst), .flush(s_flush), .ready(s_ready),
        .lu_valid(s_lu_valid), .lu_pc(s_lu_pc),
        .pred_valid(s_pred_valid), .pred_taken(s_pred_taken),
        .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_taken(s_upd_taken),
        .upd_mispredict(s_upd_mis),
        .stat_branches(s_stat_br), .stat_mispred(s_stat_mis)
    );

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        lu_v;
        logic [31:0] lu_a;
        logic        up_v;
        logic [31:0] up_a;
        logic        up_t;
        logic        up_m;
        logic        e_pv;
        logic        e_pt;
        logic [15:0] e_br;
        logic [15:0] e_mis;
    } vec_t;

    vec_t tbl[22];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // lu_v lu_pc up_v up_pc up_t up_m | pv pt br mis
        tbl[0]  = '{1'b1, 32'h40, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0,  16'd0};
        tbl[1]  = '{1'b0, 32'h00, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1,  16'd0};
        tbl[2]  = '{1'b0, 32'h00, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2,  16'd1};
        tbl[3]  = '{1'b1, 32'h44, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2,  16'd1};
        tbl[4]  = '{1'b0, 32'h00, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3,  16'd1};
        tbl[5]  = '{1'b0, 32'h00, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4,  16'd1};
        tbl[6]  = '{1'b0, 32'h00, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5,  16'd1};
        tbl[7]  = '{1'b0, 32'h00, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b1, 16'd6,  16'd2};
        tbl[8]  = '{1'b1, 32'h44, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd6,  16'd2};
        tbl[9]  = '{1'b0, 32'h00, 1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 1'b0, 16'd7,  16'd2};
        tbl[10] = '{1'b0, 32'h00, 1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 1'b0, 16'd8,  16'd2};
        tbl[11] = '{1'b1, 32'h48, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd8,  16'd2};
        tbl[12] = '{1'b0, 32'h00, 1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 1'b1, 16'd9,  16'd2};
        tbl[13] = '{1'b0, 32'h00, 1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 1'b1, 16'd10, 16'd2};
        tbl[14] = '{1'b1, 32'h48, 1'b1, 32'h48, 1'b1, 1'b0, 1'b1, 1'b1, 16'd11, 16'd2};
        tbl[15] = '{1'b0, 32'h00, 1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 1'b1, 16'd12, 16'd2};
        tbl[16] = '{1'b1, 32'h4C, 1'b1, 32'h48, 1'b1, 1'b0, 1'b1, 1'b0, 16'd13, 16'd2};
        tbl[17] = '{1'b1, 32'h48, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd13, 16'd2};
        tbl[18] = '{1'b1, 32'h48, 1'b1, 32'h48, 1'b0, 1'b0, 1'b1, 1'b0, 16'd14, 16'd2};
        tbl[19] = '{1'b1, 32'h7C, 1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 1'b0, 16'd15, 16'd3};
        tbl[20] = '{1'b0, 32'h00, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 16'd16, 16'd3};
        tbl[21] = '{1'b1, 32'h46, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd16, 16'd3};

        rst = 1'b1; flush = 1'b0; lu_valid = 1'b0; lu_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mis = 1'b0;
        s_rst = 1'b1; s_flush = 1'b0; s_lu_valid = 1'b0; s_lu_pc = '0;
        s_upd_valid = 1'b0; s_upd_pc = 32'h44; s_upd_taken = 1'b1; s_upd_mis = 1'b1;

        // Reset state
        step(); step();
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst pred_valid", 32'(pred_valid), 32'd0);
        chk("rst pred_taken", 32'(pred_taken), 32'd0);
        chk("rst stat_br", 32'(stat_br), 32'd0);
        chk("rst stat_mis", 32'(stat_mis), 32'd0);

        // INIT sweep with lookups and updates every cycle (all ignored)
        rst = 1'b0;
        lu_valid = 1'b1; lu_pc = 32'h40;
        upd_valid = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1; upd_mis = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("init%0d ready", i), 32'(ready), (i == 16) ? 32'd1 : 32'd0);
            chk($sformatf("init%0d pred_valid", i), 32'(pred_valid), 32'd0);
        end
        chk("init stat_br", 32'(stat_br), 32'd0);
        chk("init stat_mis", 32'(stat_mis), 32'd0);

        // Table-driven READY vectors
        for (int i = 0; i < 22; i++) begin
            lu_valid = tbl[i].lu_v; lu_pc = tbl[i].lu_a;
            upd_valid = tbl[i].up_v; upd_pc = tbl[i].up_a;
            upd_taken = tbl[i].up_t; upd_mis = tbl[i].up_m;
            step();
            chk($sformatf("v%0d pred_valid", i), 32'(pred_valid), 32'(tbl[i].e_pv));
            chk($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(tbl[i].e_pt));
            chk($sformatf("v%0d stat_br", i), 32'(stat_br), 32'(tbl[i].e_br));
            chk($sformatf("v%0d stat_mis", i), 32'(stat_mis), 32'(tbl[i].e_mis));
        end

        // Drive idx2 to strong-taken, so the re-init sweep is observable
        lu_valid = 1'b0; upd_valid = 1'b1; upd_pc = 32'h48; upd_taken = 1'b1; upd_mis = 1'b0;
        step();
        lu_valid = 1'b1; lu_pc = 32'h48;
        step();
        chk("pre-flush pred_taken", 32'(pred_taken), 32'd1);
        chk("pre-flush stat_br", 32'(stat_br), 32'd18);

        // Flush in READY with concurrent update and lookup: both dropped
        flush = 1'b1; upd_pc = 32'h48; upd_taken = 1'b0; upd_mis = 1'b1; lu_pc = 32'h44;
        step();
        chk("flush ready", 32'(ready), 32'd0);
        chk("flush pred_valid", 32'(pred_valid), 32'd0);
        chk("flush stat_br", 32'(stat_br), 32'd18);
        chk("flush stat_mis", 32'(stat_mis), 32'd3);
        flush = 1'b0; upd_valid = 1'b0; lu_pc = 32'h48;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("reinit%0d ready", i), 32'(ready), (i == 16) ? 32'd1 : 32'd0);
        end
        step();
        chk("post-flush pred_valid", 32'(pred_valid), 32'd1);
        chk("post-flush pred_taken", 32'(pred_taken), 32'd0);

        // Flush mid-INIT at ptr=7 restarts the sweep
        lu_valid = 1'b0; flush = 1'b1;
        step();
        chk("flush2 ready", 32'(ready), 32'd0);
        flush = 1'b0;
        for (int i = 0; i < 7; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("midinit%0d ready", i), 32'(ready), (i == 16) ? 32'd1 : 32'd0);
        end

        // Statistics saturation on the STAT_W=4 instance
        s_rst = 1'b0;
        for (int i = 0; i < 16; i++) step();
        chk("s ready", 32'(s_ready), 32'd1);
        s_upd_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("s%0d stat_br", i), 32'(s_stat_br), (i > 15) ? 32'd15 : 32'(i));
            chk($sformatf("s%0d stat_mis", i), 32'(s_stat_mis), (i > 15) ? 32'd15 : 32'(i));
        end
        s_upd_valid = 1'b0; s_rst = 1'b1;
        step();
        chk("s rst stat_br", 32'(s_stat_br), 32'd0);
        chk("s rst stat_mis", 32'(s_stat_mis), 32'd0);
        chk("s rst ready", 32'(s_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bht_controller.md
Name: bht_controller

Overview:
- Branch history table (BHT) controller that owns an array of 2-bit saturating branch-prediction counters.
- Serves one prediction lookup and one resolved-branch update per cycle.
- Sequences table initialisation after reset or flush, and keeps saturating misprediction statistics.
- Sits between the IF stage, which issues lookups, and the EX stage, which retires branch outcomes.

Parameters:
- ENTRIES, 16, number of 2-bit counters; must be a power of 2.
- IDX_W, 4, index width; equals log2(ENTRIES).
- PC_W, 32, program-counter width.
- INIT_VAL, 2'b01, counter value written during init (weakly not-taken).
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  request to re-initialise the table; ignored while rst is high.
- ready  out  1  high when in READY state (table valid).
- lu_valid  in  1  lookup request.
- lu_pc  in  PC_W  branch PC to predict.
- pred_valid  out  1  registered; prediction available this cycle.
- pred_taken  out  1  registered; MSB of the counter looked up.
- upd_valid  in  1  resolved-branch update.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  actual branch outcome.
- upd_mispredict  in  1  EX detected a misprediction for this branch.
- stat_branches  out  STAT_W  accepted updates; saturating.
- stat_mispred  out  STAT_W  accepted updates with upd_mispredict=1; saturating.

Behaviour:
- Index: idx = pc[IDX_W+1:2]. Word-aligned PCs; bits [1:0] are ignored.
- States: INIT and READY.
- Reset (rst=1 at a clock edge), with priority over everything:
  - state=INIT, sweep pointer=0.
  - pred_valid=0, pred_taken=0, ready=0.
  - stat_branches=0, stat_mispred=0.
  - Counter array contents are don't-care until the sweep overwrites them.
- INIT:
  - Writes INIT_VAL to entry[ptr] each cycle, then ptr+1.
  - After writing entry ENTRIES-1, moves to READY on the next edge. ready=1 exactly ENTRIES cycles after rst deasserts.
  - Lookups are ignored (pred_valid=0). Updates are dropped: no counter or stat change.
  - flush in INIT restarts the sweep at ptr=0.
- READY:
  - flush=1: go to INIT next cycle, ptr=0. Any lookup or update in the same cycle is dropped. Stats are preserved.
  - Lookup: pred_valid=lu_valid registered, giving 1-cycle latency. pred_taken = MSB of the counter value at the edge.
    - If upd_valid hits the same idx in the same cycle, pred_taken reflects the post-update value (forwarding).
    - pred_taken holds its last value when pred_valid=0.
  - Update: counter is saturating.
    - upd_taken=1: 11 stays 11, otherwise +1.
    - upd_taken=0: 00 stays 00, otherwise -1.
    - Written at the edge.
    - stat_branches increments and stat_mispred increments if upd_mispredict; both hold at all-ones.
  - Lookup and update to different indices in the same cycle are fully independent.
- Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is taken iff MSB=1.
- Storage is a register array, not an SRAM macro; reads are combinational from the array, results registered.

Test Plan:
- Reset for 2 cycles, release, lookups every cycle → ready rises exactly 16 cycles after release; pred_valid=0 throughout INIT; first READY lookup of pc 0x40 → pred_taken=0 (INIT_VAL=01).
- In READY, 2 updates taken to pc 0x44, then lookup 0x44 → counter 11, pred_taken=1. Then 3 updates not-taken → counter 00. A 4th not-taken keeps it at 00, and lookup → 0.
- Same cycle: update taken to 0x48 (counter 01) plus lookup 0x48 → next cycle pred_valid=1, pred_taken=1 (forwarded 10). Same stimulus with lookup of 0x4C → pred_taken=0.
- Alias check: pc 0x08 and 0x48 share idx 2. Two taken updates via 0x08 → lookup 0x48 gives pred_taken=1.
- Assert flush mid-INIT at ptr=7 → ready rises 16 cycles after flush. Assert flush in READY with a concurrent update → update dropped, stats unchanged, ready=0 next cycle.
- With STAT_W=4, apply 20 updates with upd_mispredict=1 → stat_branches=stat_mispred=15 (saturated); rst → both 0.
